// File: rtl/pic_pkg.sv
// Shared constants, FSM encoding and priority helper for the PIC priority resolver.
package pic_pkg;

    localparam int N_IR    = 8;
    localparam int LEVEL_W = 3;

    localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7;
    localparam logic [LEVEL_W-1:0] LP_RESET       = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } pic_state_e;

    // Rank of a level under the current lowest-priority pointer: 0 is highest.
    function automatic logic [LEVEL_W-1:0] prio_rank(input logic [LEVEL_W-1:0] level,
                                                     input logic [LEVEL_W-1:0] lp);
        return level - lp - 3'd1;
    endfunction

endpackage

// File: rtl/pic_rot_prio_enc.sv
// Rotating find-first encoder: the search starts at lp+1 and wraps around.
module pic_rot_prio_enc
    import pic_pkg::*;
(
    input  logic [N_IR-1:0]    vec,
    input  logic [LEVEL_W-1:0] lp,
    output logic               valid,
    output logic [LEVEL_W-1:0] level
);

    // Scan from lowest priority to highest so the highest-priority hit is written last.
    always_comb begin
        valid = 1'b0;
        level = lp + 3'd1;
        for (int i = N_IR - 1; i >= 0; i--) begin
            if (vec[lp + 3'd1 + LEVEL_W'(i)]) begin
                valid = 1'b1;
                level = lp + 3'd1 + LEVEL_W'(i);
            end else begin
                valid = valid;
                level = level;
            end
        end
    end

endmodule

// File: rtl/pic_priority_resolver.sv
// IRR capture, fully nested priority resolution and INTA handshake of the PIC.
// Optional feature macro: PIC_PR_ROTATION_EN (priority rotation). When it is
// undefined the lowest-priority pointer is fixed at 7 and the rotation inputs
// are ignored.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_IR-1:0]     ir_req,
    input  logic                ltim,
    input  logic [N_IR-1:0]     imr,
    input  logic [N_IR-1:0]     isr,
    input  logic                inta_n,
    input  logic                eoi_pulse,
    input  logic                rotate_on_eoi,
    input  logic                specific_rotate,
    input  logic [LEVEL_W-1:0]  rot_level,
    output logic [N_IR-1:0]     irr,
    output logic                int_out,
    output logic [LEVEL_W-1:0]  highest_priority_int,
    output logic                isr_set,
    output logic                spurious
);

    pic_state_e          state_r;
    logic [N_IR-1:0]     irr_r;
    logic [N_IR-1:0]     ir_prev_r;
    logic                inta_prev_r;
    logic                int_out_r;
    logic                isr_set_r;
    logic                spurious_r;
    logic [LEVEL_W-1:0]  hpi_r;

    logic [LEVEL_W-1:0]  lp_s;
    logic [N_IR-1:0]     pend_s;
    logic [N_IR-1:0]     ack_clr_s;
    logic [N_IR-1:0]     irr_next_s;
    logic                pend_valid_s;
    logic [LEVEL_W-1:0]  pend_level_s;
    logic                isr_valid_s;
    logic [LEVEL_W-1:0]  isr_level_s;
    logic                inta_fall_s;
    logic                ack2_entry_s;
    logic                int_req_s;

`ifdef PIC_PR_ROTATION_EN
    logic [LEVEL_W-1:0]  lp_r;

    // Lowest-priority pointer: specific rotate overrides rotate-on-EOI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_r <= LP_RESET;
        end else if (specific_rotate) begin
            lp_r <= rot_level;
        end else if (eoi_pulse && rotate_on_eoi && isr_valid_s) begin
            lp_r <= isr_level_s;
        end else begin
            lp_r <= lp_r;
        end
    end

    assign lp_s = lp_r;
`else
    logic unused_rot_s;

    assign lp_s         = LP_RESET;
    assign unused_rot_s = ^{eoi_pulse, rotate_on_eoi, specific_rotate, rot_level};
`endif

    assign pend_s       = irr_r & ~imr;
    assign inta_fall_s  = inta_prev_r & ~inta_n;
    assign ack2_entry_s = (state_r == ACK1) && inta_fall_s;

    pic_rot_prio_enc u_pend_enc (
        .vec   (pend_s),
        .lp    (lp_s),
        .valid (pend_valid_s),
        .level (pend_level_s)
    );

    pic_rot_prio_enc u_isr_enc (
        .vec   (isr),
        .lp    (lp_s),
        .valid (isr_valid_s),
        .level (isr_level_s)
    );

    // Fully nested rule: request only when the candidate outranks everything in service.
    assign int_req_s = pend_valid_s &&
                       (!isr_valid_s ||
                        (prio_rank(pend_level_s, lp_s) < prio_rank(isr_level_s, lp_s)));

    // Acknowledge clear mask for the frozen level, applied on entry to ACK2.
    always_comb begin
        if (ack2_entry_s) begin
            ack_clr_s = 8'h01 << hpi_r;
        end else begin
            ack_clr_s = 8'h00;
        end
    end

    // Next IRR: level follows the line, edge latches rises; acknowledge clear wins last.
    always_comb begin
        irr_next_s = irr_r;
        if (ltim) begin
            irr_next_s = ir_req;
        end else if (state_r == ACK1) begin
            irr_next_s = irr_r | (ir_req & ~ir_prev_r);
        end else begin
            irr_next_s = (irr_r | (ir_req & ~ir_prev_r)) & ir_req;
        end
        irr_next_s = irr_next_s & ~ack_clr_s;
    end

    // IRR and the edge/INTA history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irr_r       <= 8'h00;
            ir_prev_r   <= 8'h00;
            inta_prev_r <= 1'b1;
        end else begin
            irr_r       <= irr_next_s;
            ir_prev_r   <= ir_req;
            inta_prev_r <= inta_n;
        end
    end

    // INTA handshake FSM with registered int_out, frozen level, isr_set and spurious.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            int_out_r  <= 1'b0;
            hpi_r      <= 3'd0;
            isr_set_r  <= 1'b0;
            spurious_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    isr_set_r <= 1'b0;
                    if (inta_fall_s) begin
                        state_r <= ACK1;
                        if (pend_valid_s) begin
                            hpi_r      <= pend_level_s;
                            spurious_r <= 1'b0;
                        end else begin
                            hpi_r      <= SPURIOUS_LEVEL;
                            spurious_r <= 1'b1;
                        end
                    end else begin
                        state_r   <= IDLE;
                        int_out_r <= int_req_s;
                    end
                end
                ACK1: begin
                    if (inta_fall_s) begin
                        state_r   <= ACK2;
                        isr_set_r <= ~spurious_r;
                        int_out_r <= 1'b0;
                    end else begin
                        state_r <= ACK1;
                    end
                end
                ACK2: begin
                    state_r    <= IDLE;
                    isr_set_r  <= 1'b0;
                    int_out_r  <= 1'b0;
                    spurious_r <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    isr_set_r  <= 1'b0;
                    int_out_r  <= 1'b0;
                    spurious_r <= 1'b0;
                end
            endcase
        end
    end

    assign irr                  = irr_r;
    assign int_out              = int_out_r;
    assign highest_priority_int = hpi_r;
    assign isr_set              = isr_set_r;
    assign spurious             = spurious_r;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Directed scoreboard bench for pic_priority_resolver.
module tb_pic_priority_resolver;

    logic       clk;
    logic       rst_n;
    logic [7:0] ir_req;
    logic       ltim;
    logic [7:0] imr;
    logic [7:0] isr;
    logic       inta_n;
    logic       eoi_pulse;
    logic       rotate_on_eoi;
    logic       specific_rotate;
    logic [2:0] rot_level;
    logic [7:0] irr;
    logic       int_out;
    logic [2:0] highest_priority_int;
    logic       isr_set;
    logic       spurious;

    typedef struct packed {
        logic [2:0] level;
        logic       spur;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    pic_priority_resolver dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ir_req               (ir_req),
        .ltim                 (ltim),
        .imr                  (imr),
        .isr                  (isr),
        .inta_n               (inta_n),
        .eoi_pulse            (eoi_pulse),
        .rotate_on_eoi        (rotate_on_eoi),
        .specific_rotate      (specific_rotate),
        .rot_level            (rot_level),
        .irr                  (irr),
        .int_out              (int_out),
        .highest_priority_int (highest_priority_int),
        .isr_set              (isr_set),
        .spurious             (spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // First INTA pulse; afterwards the DUT is in ACK1.
    task automatic ack1();
        inta_n = 1'b0;
        tick();
        inta_n = 1'b1;
    endtask

    // Second INTA pulse; afterwards the DUT is in ACK2.
    task automatic ack2();
        tick();
        inta_n = 1'b0;
        tick();
        inta_n = 1'b1;
    endtask

    task automatic check_ack(input logic spur_evt);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_unexpected: actual level %0d with no expected acknowledge", highest_priority_int);
        end else begin
            e = exp_q.pop_front();
            chk("ack_level", {29'd0, highest_priority_int}, {29'd0, e.level});
            chk("ack_kind_spurious", {31'd0, spur_evt}, {31'd0, e.spur});
        end
    endtask

    // Monitor: an acknowledge completes on isr_set, or on spurious falling.
    task automatic monitor_loop();
        logic spur_prev;
        spur_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (isr_set === 1'b1) check_ack(1'b0);
            if (spur_prev && (spurious === 1'b0)) check_ack(1'b1);
            spur_prev = (spurious === 1'b1);
        end
    endtask

    initial begin
        logic [2:0] rot_exp;
        logic [7:0] irr_exp;

        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        ir_req          = 8'h00;
        ltim            = 1'b0;
        imr             = 8'h00;
        isr             = 8'h00;
        inta_n          = 1'b1;
        eoi_pulse       = 1'b0;
        rotate_on_eoi   = 1'b0;
        specific_rotate = 1'b0;
        rot_level       = 3'd0;

        fork
            monitor_loop();
            begin
                #100000;
                $display("FAIL watchdog: time limit reached");
                $fatal(1, "time limit");
            end
        join_none

        // Reset values
        ticks(2);
        chk("rst_irr", {24'd0, irr}, 32'h0);
        chk("rst_int_out", {31'd0, int_out}, 32'h0);
        chk("rst_hpi", {29'd0, highest_priority_int}, 32'h0);
        chk("rst_isr_set", {31'd0, isr_set}, 32'h0);
        chk("rst_spurious", {31'd0, spurious}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Edge mode: IR3 and IR5 together
        ir_req = 8'h28;
        tick();
        chk("t1_irr_set", {24'd0, irr}, 32'h28);
        chk("t1_int_out_n1", {31'd0, int_out}, 32'h0);
        tick();
        chk("t1_int_out_n2", {31'd0, int_out}, 32'h1);
        exp_q.push_back('{level: 3'd3, spur: 1'b0});
        ack1();
        chk("t1_hpi", {29'd0, highest_priority_int}, 32'h3);
        chk("t1_int_out_ack1", {31'd0, int_out}, 32'h1);
        ack2();
        chk("t1_isr_set", {31'd0, isr_set}, 32'h1);
        chk("t1_irr_clr", {24'd0, irr}, 32'h20);
        chk("t1_int_out_ack2", {31'd0, int_out}, 32'h0);
        isr = 8'h08;
        tick();
        chk("t1_isr_set_once", {31'd0, isr_set}, 32'h0);
        ticks(2);
        chk("t1_nested_block", {31'd0, int_out}, 32'h0);
        isr    = 8'h00;
        ir_req = 8'h00;
        ticks(3);
        chk("t1_cleanup_irr", {24'd0, irr}, 32'h0);
        chk("t1_cleanup_int", {31'd0, int_out}, 32'h0);

        // Nesting: IR6 under in-service IR2 is held off, IR1 gets through
        isr    = 8'h04;
        ir_req = 8'h40;
        ticks(3);
        chk("t2_irr", {24'd0, irr}, 32'h40);
        chk("t2_int_out_low", {31'd0, int_out}, 32'h0);
        ir_req = 8'h42;
        ticks(2);
        chk("t2_int_out_high", {31'd0, int_out}, 32'h1);
        exp_q.push_back('{level: 3'd1, spur: 1'b0});
        ack1();
        chk("t2_hpi", {29'd0, highest_priority_int}, 32'h1);
        ack2();
        chk("t2_irr_clr", {24'd0, irr}, 32'h40);
        tick();
        isr    = 8'h00;
        ir_req = 8'h00;
        ticks(3);
        chk("t2_cleanup_irr", {24'd0, irr}, 32'h0);

        // Level mode: IR2 held high through acknowledge
        ltim   = 1'b1;
        ir_req = 8'h04;
        tick();
        chk("t3_irr", {24'd0, irr}, 32'h04);
        tick();
        chk("t3_int_out", {31'd0, int_out}, 32'h1);
        exp_q.push_back('{level: 3'd2, spur: 1'b0});
        ack1();
        chk("t3_hpi", {29'd0, highest_priority_int}, 32'h2);
        ack2();
        chk("t3_irr_ack2", {24'd0, irr}, 32'h00);
        chk("t3_isr_set", {31'd0, isr_set}, 32'h1);
        tick();
        chk("t3_irr_reset", {24'd0, irr}, 32'h04);
        chk("t3_int_out_idle0", {31'd0, int_out}, 32'h0);
        tick();
        chk("t3_int_out_reassert", {31'd0, int_out}, 32'h1);
        ir_req = 8'h00;
        tick();
        ltim = 1'b0;
        ticks(3);
        chk("t3_cleanup_int", {31'd0, int_out}, 32'h0);

        // Spurious: IR4 dropped before the first INTA
        ir_req = 8'h10;
        tick();
        chk("t4_irr", {24'd0, irr}, 32'h10);
        tick();
        chk("t4_int_out", {31'd0, int_out}, 32'h1);
        ir_req = 8'h00;
        tick();
        chk("t4_irr_drop", {24'd0, irr}, 32'h00);
        tick();
        chk("t4_int_out_drop", {31'd0, int_out}, 32'h0);
        exp_q.push_back('{level: 3'd7, spur: 1'b1});
        ack1();
        chk("t4_hpi", {29'd0, highest_priority_int}, 32'h7);
        chk("t4_spurious", {31'd0, spurious}, 32'h1);
        ack2();
        chk("t4_no_isr_set", {31'd0, isr_set}, 32'h0);
        chk("t4_spurious_ack2", {31'd0, spurious}, 32'h1);
        tick();
        chk("t4_spurious_idle", {31'd0, spurious}, 32'h0);
        chk("t4_no_isr_set_idle", {31'd0, isr_set}, 32'h0);

        // Rotation: lowest priority set to 4, IR0 and IR5 pending
`ifdef PIC_PR_ROTATION_EN
        rot_exp = 3'd5;
`else
        rot_exp = 3'd0;
`endif
        irr_exp = 8'h21 & ~(8'h01 << rot_exp);
        specific_rotate = 1'b1;
        rot_level       = 3'd4;
        tick();
        specific_rotate = 1'b0;
        rot_level       = 3'd0;
        ir_req          = 8'h21;
        ticks(2);
        chk("t5_int_out", {31'd0, int_out}, 32'h1);
        exp_q.push_back('{level: rot_exp, spur: 1'b0});
        ack1();
        chk("t5_hpi", {29'd0, highest_priority_int}, {29'd0, rot_exp});
        ack2();
        chk("t5_irr_clr", {24'd0, irr}, {24'd0, irr_exp});
        tick();
        ir_req = 8'h00;
        ticks(3);

        // Reset while in ACK1, then a fresh acknowledge
        ir_req = 8'h08;
        ticks(2);
        ack1();
        chk("t6_hpi_before", {29'd0, highest_priority_int}, 32'h3);
        rst_n  = 1'b0;
        ir_req = 8'h00;
        #1;
        chk("t6_rst_irr", {24'd0, irr}, 32'h0);
        chk("t6_rst_int_out", {31'd0, int_out}, 32'h0);
        chk("t6_rst_hpi", {29'd0, highest_priority_int}, 32'h0);
        chk("t6_rst_isr_set", {31'd0, isr_set}, 32'h0);
        chk("t6_rst_spurious", {31'd0, spurious}, 32'h0);
        ticks(2);
        rst_n = 1'b1;
        tick();
        ir_req = 8'h21;
        tick();
        chk("t6_irr", {24'd0, irr}, 32'h21);
        tick();
        chk("t6_int_out", {31'd0, int_out}, 32'h1);
        exp_q.push_back('{level: 3'd0, spur: 1'b0});
        ack1();
        chk("t6_hpi", {29'd0, highest_priority_int}, 32'h0);
        ack2();
        chk("t6_isr_set", {31'd0, isr_set}, 32'h1);
        chk("t6_irr_clr", {24'd0, irr}, 32'h20);
        tick();
        ir_req = 8'h00;
        ticks(3);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
